// File: rtl/inst_fetch_unit.sv
// PC register and IF/ID pipeline register for an async-read instruction ROM.
// Define FETCH_PERF_CNT_EN to add fetch/bubble performance counters.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned ROM_ADDR_W = 8,
  parameter logic [31:0] NOP_INST   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_addr,
  input  logic [31:0] rom_inst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm16,
  input  logic        jump,
  input  logic [25:0] jump_index26,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        fetch_oob
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  localparam logic [31:0] RST_PC = {RESET_PC[31:2], 2'b00};
  localparam int unsigned OOB_SH = ROM_ADDR_W + 2;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  if_id_t      if_id_q;
  if_id_t      if_id_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;

  logic sel_hold;
  logic sel_jmp;
  logic sel_br;
  logic sel_seq;

  // One-hot selects encode the stall > jump > branch > sequential priority
  assign sel_hold = stall;
  assign sel_jmp  = !stall && jump;
  assign sel_br   = !stall && !jump && branch_taken;
  assign sel_seq  = !stall && !jump && !branch_taken;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{14{branch_imm16[15]}}, branch_imm16, 2'b00};
  assign br_tgt   = (if_id_q.pc_plus4 + br_off) & 32'hFFFF_FFFC;
  assign jmp_tgt  = {if_id_q.pc_plus4[31:28], jump_index26, 2'b00};

  always_comb begin
    pc_d    = pc_q;
    if_id_d = if_id_q;
    unique case (1'b1)
      sel_hold: begin
        pc_d    = pc_q;
        if_id_d = if_id_q;
      end
      sel_jmp: begin
        pc_d          = jmp_tgt;
        if_id_d.inst  = NOP_INST;
        if_id_d.valid = 1'b0;
      end
      sel_br: begin
        pc_d          = br_tgt;
        if_id_d.inst  = NOP_INST;
        if_id_d.valid = 1'b0;
      end
      sel_seq: begin
        pc_d             = pc_plus4;
        if_id_d.inst     = rom_inst;
        if_id_d.pc_plus4 = pc_plus4;
        if_id_d.valid    = 1'b1;
      end
      default: begin
        pc_d    = pc_q;
        if_id_d = if_id_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q             <= RST_PC;
      if_id_q.inst     <= NOP_INST;
      if_id_q.pc_plus4 <= 32'd0;
      if_id_q.valid    <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
    end
  end

  assign pc_addr        = pc_q;
  assign if_id_inst     = if_id_q.inst;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;
  assign if_id_valid    = if_id_q.valid;
  assign fetch_oob      = (pc_q >> OOB_SH) != 32'd0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (sel_seq) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (!sel_seq) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: spec-level model plus literal spot checks.
// Two extra instances cover a high reset PC and the 2^32 PC wrap.
module tb_inst_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rom [256];

  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_imm16;
  logic        jump;
  logic [25:0] jump_index26;
  logic [31:0] pc_addr;
  logic [31:0] rom_inst;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        fetch_oob;

  logic        h_rst_n;
  logic        h_branch;
  logic        h_jump;
  logic [15:0] h_imm;
  logic [25:0] h_idx;
  logic [31:0] h_pc;
  logic [31:0] h_rom;
  logic [31:0] h_inst;
  logic [31:0] h_pp4;
  logic        h_valid;
  logic        h_oob;

  logic        w_zero;
  logic [15:0] w_imm;
  logic [25:0] w_idx;
  logic [31:0] w_pc;
  logic [31:0] w_rom;
  logic [31:0] w_inst;
  logic [31:0] w_pp4;
  logic        w_valid;
  logic        w_oob;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
  logic [31:0] h_pf;
  logic [31:0] h_pb;
  logic [31:0] w_pf;
  logic [31:0] w_pb;
`endif

  assign rom_inst = rom[pc_addr[9:2]];
  assign h_rom    = rom[h_pc[9:2]];
  assign w_rom    = rom[w_pc[9:2]];

  inst_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr), .rom_inst(rom_inst),
    .stall(stall), .branch_taken(branch_taken),
    .branch_imm16(branch_imm16), .jump(jump),
    .jump_index26(jump_index26), .if_id_inst(if_id_inst),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
    .fetch_oob(fetch_oob)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  inst_fetch_unit #(.RESET_PC(32'h1000_000C)) u_hi (
    .clk(clk), .rst_n(h_rst_n), .pc_addr(h_pc), .rom_inst(h_rom),
    .stall(1'b0), .branch_taken(h_branch), .branch_imm16(h_imm),
    .jump(h_jump), .jump_index26(h_idx), .if_id_inst(h_inst),
    .if_id_pc_plus4(h_pp4), .if_id_valid(h_valid), .fetch_oob(h_oob)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(h_pf), .perf_bubble_cnt(h_pb)
`endif
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst_n(h_rst_n), .pc_addr(w_pc), .rom_inst(w_rom),
    .stall(w_zero), .branch_taken(w_zero), .branch_imm16(w_imm),
    .jump(w_zero), .jump_index26(w_idx), .if_id_inst(w_inst),
    .if_id_pc_plus4(w_pp4), .if_id_valid(w_valid), .fetch_oob(w_oob)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(w_pf), .perf_bubble_cnt(w_pb)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_pp4;
  logic        m_valid;
  logic [31:0] m_fet;
  logic [31:0] m_bub;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'd0;
    m_inst  = 32'd0;
    m_pp4   = 32'd0;
    m_valid = 1'b0;
    m_fet   = 32'd0;
    m_bub   = 32'd0;
  endtask

  task automatic model_step();
    logic [31:0] off;
    if (!rst_n) begin
      model_reset();
    end else if (stall) begin
      m_bub = m_bub + 1;
    end else if (jump) begin
      m_pc    = (m_pp4 & 32'hF000_0000) | ({6'd0, jump_index26} * 4);
      m_inst  = 32'd0;
      m_valid = 1'b0;
      m_bub   = m_bub + 1;
    end else if (branch_taken) begin
      off     = 32'($signed(branch_imm16));
      m_pc    = m_pp4 + off * 4;
      m_inst  = 32'd0;
      m_valid = 1'b0;
      m_bub   = m_bub + 1;
    end else begin
      m_inst  = rom[(m_pc / 4) % 256];
      m_pc    = m_pc + 4;
      m_pp4   = m_pc;
      m_valid = 1'b1;
      m_fet   = m_fet + 1;
    end
  endtask

  task automatic compare_main();
    chk("pc_addr", pc_addr, m_pc);
    chk("if_id_inst", if_id_inst, m_inst);
    chk("if_id_pc_plus4", if_id_pc_plus4, m_pp4);
    chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    chk("fetch_oob", {31'd0, fetch_oob}, {31'd0, (m_pc >= 32'd1024)});
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, m_fet);
    chk("perf_bubble_cnt", perf_bubble_cnt, m_bub);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_main();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'hA500_0000 | i;
    rom[1] = 32'h0043_0822;
    stall = 0; branch_taken = 0; branch_imm16 = 0;
    jump = 0; jump_index26 = 0;
    h_branch = 0; h_jump = 0; h_imm = 0; h_idx = 0;
    w_zero = 0; w_imm = 0; w_idx = 0;
    rst_n = 1; h_rst_n = 1;
    #1;
    rst_n = 0; h_rst_n = 0;
    model_reset();
    @(negedge clk);
    compare_main();
    chk("rst_pc", pc_addr, 32'h0);
    chk("rst_inst", if_id_inst, 32'h0);
    chk("rst_pp4", if_id_pc_plus4, 32'h0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("hi_rst_pc", h_pc, 32'h1000_000C);

    rst_n = 1; h_rst_n = 1;
    tick();
    chk("seq_pc1", pc_addr, 32'h4);
    chk("hi_pc1", h_pc, 32'h1000_0010);
    chk("hi_pp4_1", h_pp4, 32'h1000_0010);
    chk("wrap_pc1", w_pc, 32'hFFFF_FFFC);
    chk("wrap_oob1", {31'd0, w_oob}, 32'd1);

    h_jump = 1; h_branch = 1; h_idx = 26'h000_0040; h_imm = 16'h0003;
    tick();
    chk("seq_pc2", pc_addr, 32'h8);
    chk("seq_inst2", if_id_inst, 32'h0043_0822);
    chk("seq_pp4_2", if_id_pc_plus4, 32'h8);
    chk("seq_valid2", {31'd0, if_id_valid}, 32'd1);
    chk("hi_jump_pc", h_pc, 32'h1000_0100);
    chk("hi_jump_valid", {31'd0, h_valid}, 32'd0);
    chk("hi_jump_inst", h_inst, 32'h0);
    chk("wrap_pc2", w_pc, 32'h0);
    chk("wrap_pp4_2", w_pp4, 32'h0);
    chk("wrap_valid2", {31'd0, w_valid}, 32'd1);
    h_jump = 0; h_branch = 0;

    tick();
    chk("seq_pc3", pc_addr, 32'hC);

    stall = 1;
    repeat (3) tick();
    chk("stall_pc", pc_addr, 32'hC);
    chk("stall_pp4", if_id_pc_plus4, 32'hC);
    chk("stall_inst", if_id_inst, rom[2]);
    stall = 0;
    tick();
    chk("unstall_pc", pc_addr, 32'h10);

    repeat (5) tick();
    chk("pre_rst_pc", pc_addr, 32'h24);

    #3;
    rst_n = 0; branch_taken = 1; branch_imm16 = 16'h0003;
    #1;
    model_reset();
    chk("async_rst_pc", pc_addr, 32'h0);
    chk("async_rst_valid", {31'd0, if_id_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("async_rst_pf", perf_fetch_cnt, 32'd0);
    chk("async_rst_pb", perf_bubble_cnt, 32'd0);
`endif
    compare_main();
    @(negedge clk);
    rst_n = 1; branch_taken = 0;
    compare_main();

    repeat (3) tick();
    chk("br_setup_pp4", if_id_pc_plus4, 32'hC);
    branch_taken = 1; branch_imm16 = 16'h0003;
    tick();
    chk("br_fwd_pc", pc_addr, 32'h18);
    chk("br_fwd_valid", {31'd0, if_id_valid}, 32'd0);
    chk("br_fwd_inst", if_id_inst, 32'h0);
    branch_imm16 = 16'hFFFE;
    tick();
    chk("br_back_pc", pc_addr, 32'h4);
    branch_imm16 = 16'h0003; stall = 1;
    tick();
    chk("br_stall_pc", pc_addr, 32'h4);
    stall = 0;
    tick();
    chk("br_after_stall_pc", pc_addr, 32'h18);
    branch_taken = 0;

    jump = 1; jump_index26 = 26'h000_0003;
    tick();
    chk("jump_pc", pc_addr, 32'hC);
    jump = 0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Program-counter and IF/ID pipeline-register stage sitting directly upstream of the instruction ROM.
- Drives the word-aligned fetch address into the ROM's asynchronous read port and captures the returned instruction.
- Presents a registered instruction/PC+4 pair to the decode stage.
- Handles sequential fetch, decode-stage stall, and branch/jump redirect with flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ROM_ADDR_W, 8, word-index width of the attached ROM (256 words); sets the out-of-range check.
- NOP_INST, 32'h0000_0000, instruction injected into IF/ID on flush and reset.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pc_addr  output  32  current PC, driven to ROM Addr (combinational from PC register).
- rom_inst  input  32  instruction word returned by ROM for pc_addr (same cycle).
- stall  input  1  hazard unit: hold PC and IF/ID contents.
- branch_taken  input  1  decode resolved a taken beq.
- branch_imm16  input  16  beq immediate field of the instruction in decode.
- jump  input  1  decode holds a j instruction.
- jump_index26  input  26  j target index field.
- if_id_inst  output  32  registered instruction to decode.
- if_id_pc_plus4  output  32  registered PC+4 of that instruction.
- if_id_valid  output  1  1 = if_id_inst is a real fetched instruction; 0 = bubble.
- fetch_oob  output  1  combinational; 1 when pc_addr[31:ROM_ADDR_W+2] != 0.

Behaviour:
- Reset (async, rst_n low):
  - PC=RESET_PC, if_id_inst=NOP_INST, if_id_pc_plus4=0, if_id_valid=0.
  - Outputs take these values immediately, without waiting for clk.
  - Reset mid-operation discards any pending redirect.
- pc_addr=PC. PC[1:0] is always 00, and every computed target has its low two bits forced to 00.
- The ROM is asynchronous, so fetch latency is 0 cycles to rom_inst and 1 cycle to the if_id_* outputs.
- Redirect targets, computed from if_id_pc_plus4 (the decode instruction's PC+4):
  - branch_target = if_id_pc_plus4 + (sign_extend(branch_imm16) << 2), modulo 2^32.
  - jump_target = {if_id_pc_plus4[31:28], jump_index26, 2'b00}.
- Per-edge priority (first match wins):
  1. stall=1: PC and all if_id_* hold. branch_taken and jump are ignored this cycle, because the decode instruction is held and re-presents them next cycle.
  2. jump=1: PC<=jump_target, if_id_inst<=NOP_INST, if_id_valid<=0 (flush).
  3. branch_taken=1: PC<=branch_target, flush as above.
  4. Otherwise: PC<=PC+4, if_id_inst<=rom_inst, if_id_pc_plus4<=PC+4, if_id_valid<=1.
- jump and branch_taken both high: jump wins.
- PC+4 at 32'hFFFF_FFFC wraps to 0; there is no error flag for this.
- fetch_oob is status only. Fetch proceeds regardless, and the ROM aliases the address.
- No X propagation: with rst_n deasserted, all registers are defined.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_bubble_cnt[31:0].
  - perf_fetch_cnt increments on each edge that takes priority case 4.
  - perf_bubble_cnt increments on each edge with stall=1 or a flush.
  - Both counters reset to 0 asynchronously and wrap at 2^32.
- Undefined: these ports and registers do not exist, and all other behaviour is identical.

Test Plan:
- Reset then release, stall=0, no redirects, ROM word 1 = 32'h0043_0822:
  - pc_addr steps 0,4,8,C on successive edges.
  - After the 2nd edge, if_id_inst=32'h0043_0822, if_id_pc_plus4=8, if_id_valid=1.
- Stall held 3 cycles at PC=0x0C: pc_addr stays 0x0C and if_id_* are unchanged. On release, PC goes to 0x10.
- Branch with if_id_pc_plus4=0x0C, branch_imm16=16'h0003: next PC=0x18, if_id_valid=0, if_id_inst=0. Repeat with imm=16'hFFFE: PC=0x04.
- jump=1 and branch_taken=1 together, if_id_pc_plus4=0x1000_0010, jump_index26=26'h000_0040: PC=0x1000_0100 and if_id_valid=0.
- stall=1 with branch_taken=1 (imm 0x0003): PC holds. Next cycle stall=0, branch still high: PC=target.
- Assert rst_n=0 mid-cycle while PC=0x24: pc_addr=0 and if_id_valid=0 before the next clk edge. With FETCH_PERF_CNT_EN, both counters read 0.
